// File: rtl/sha_mem_pkg.sv
// ============================================================================
// Module      : sha_mem_pkg
// Description : Shared widths, capture-state encoding and digest packing for
//               the SHA-256 memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha_mem_pkg;

    localparam int DIGEST_WORDS = 8;
    localparam int DEF_DEPTH    = 1024;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int DIGEST_W     = DIGEST_WORDS * DEF_DATA_W;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        COMPLETE = 2'd2
    } cap_state_t;

    typedef logic [DIGEST_WORDS-1:0][DEF_DATA_W-1:0] slot_array_t;

    // Slot 0 (h0) lands in the most significant word.
    function automatic logic [DIGEST_W-1:0] pack_digest(input slot_array_t slots);
        logic [DIGEST_W-1:0] packed_word;
        packed_word = '0;
        for (int k = 0; k < DIGEST_WORDS; k++) begin
            packed_word[(DIGEST_WORDS-1-k)*DEF_DATA_W +: DEF_DATA_W] = slots[k];
        end
        return packed_word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha_sp_ram.sv
// ============================================================================
// Module      : sha_sp_ram
// Description : Single-port storage array, one write port, read-first
//               registered read. Array contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_sp_ram
    import sha_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEF_DEPTH),
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Sampling the array on the same edge as the write yields the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_q <= '0;
        end else begin
            r_rdata_q <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule

`default_nettype wire

// File: rtl/sha_mem_responder.sv
// ============================================================================
// Module      : sha_mem_responder
// Description : Memory-side responder for the SHA-256 engine with a host
//               port and a snooping 256-bit digest capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                eng_busy,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_write_data,
    output logic [DATA_W-1:0]   mem_read_data,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    output logic                host_grant,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                host_rvalid,
    input  logic [ADDR_W-1:0]   digest_base,
    input  logic                digest_clear,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                addr_err
);

    localparam int                    c_IDX_W     = $clog2(DEPTH);
    localparam int                    c_SLOT_W    = $clog2(DIGEST_WORDS);
    localparam logic [ADDR_W:0]       c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]     c_SLOTS     = ADDR_W'(DIGEST_WORDS);
    localparam logic [DIGEST_WORDS-1:0] c_FULL_MASK = '1;

    logic                    w_host_own;
    logic [ADDR_W-1:0]       w_addr;
    logic                    w_we;
    logic [DATA_W-1:0]       w_wdata;
    logic                    w_oor;
    logic                    w_access;
    logic [DATA_W-1:0]       w_ram_rdata;
    logic [DATA_W-1:0]       w_rd_word;
    logic [ADDR_W-1:0]       w_offset;
    logic [c_SLOT_W-1:0]     w_slot;
    logic                    w_cap;
    logic                    w_clear;

    logic                    r_oor_q,          w_oor_d;
    logic                    r_host_rvalid_q,  w_host_rvalid_d;
    logic [DATA_W-1:0]       r_host_hold_q,    w_host_hold_d;
    logic                    r_addr_err_q,     w_addr_err_d;
    logic                    r_busy_q,         w_busy_d;
    logic [DIGEST_WORDS-1:0] r_mask_q,         w_mask_d;
    slot_array_t             r_slots_q,        w_slots_d;
    cap_state_t              r_state_q,        w_state_d;

    assign host_grant = host_req & ~eng_busy;

    always_comb begin
        w_host_own = host_grant;
        w_addr     = w_host_own ? host_addr  : mem_addr;
        w_we       = w_host_own ? host_we    : mem_we;
        w_wdata    = w_host_own ? host_wdata : mem_write_data;
        w_oor      = ({1'b0, w_addr} >= c_DEPTH);
        // An idle engine's address lines are only meaningful when it writes.
        w_access   = w_host_own | eng_busy | mem_we;
    end

    sha_sp_ram #(
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_we & ~w_oor),
        .i_idx   (w_addr[c_IDX_W-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_rd_word     = r_oor_q ? '0 : w_ram_rdata;
    assign mem_read_data = w_rd_word;
    assign host_rdata    = r_host_rvalid_q ? w_rd_word : r_host_hold_q;
    assign host_rvalid   = r_host_rvalid_q;
    assign addr_err      = r_addr_err_q;
    assign digest_valid  = (r_state_q == COMPLETE);
    assign digest        = pack_digest(r_slots_q);

    always_comb begin
        w_oor_d         = w_oor;
        w_host_rvalid_d = w_host_own & ~host_we;
        w_host_hold_d   = r_host_rvalid_q ? w_rd_word : r_host_hold_q;
        w_addr_err_d    = r_addr_err_q | (w_access & w_oor);
        w_busy_d        = eng_busy;

        w_offset = mem_addr - digest_base;
        w_slot   = w_offset[c_SLOT_W-1:0];
        w_cap    = eng_busy & mem_we & ~w_oor & (w_offset < c_SLOTS);
        w_clear  = digest_clear | (eng_busy & ~r_busy_q);

        // Clear first so a same-cycle capture write survives it.
        w_mask_d  = w_clear ? '0 : r_mask_q;
        w_slots_d = r_slots_q;
        if (w_cap) begin
            w_mask_d[w_slot]  = 1'b1;
            w_slots_d[w_slot] = mem_write_data;
        end

        w_state_d = r_state_q;
        case (r_state_q)
            EMPTY, FILLING, COMPLETE: begin
                if (w_mask_d == '0) begin
                    w_state_d = EMPTY;
                end else if (w_mask_d == c_FULL_MASK) begin
                    w_state_d = COMPLETE;
                end else begin
                    w_state_d = FILLING;
                end
            end
            default: w_state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_oor_q         <= 1'b0;
            r_host_rvalid_q <= 1'b0;
            r_host_hold_q   <= '0;
            r_addr_err_q    <= 1'b0;
            r_busy_q        <= 1'b0;
            r_mask_q        <= '0;
            r_slots_q       <= '0;
            r_state_q       <= EMPTY;
        end else begin
            r_oor_q         <= w_oor_d;
            r_host_rvalid_q <= w_host_rvalid_d;
            r_host_hold_q   <= w_host_hold_d;
            r_addr_err_q    <= w_addr_err_d;
            r_busy_q        <= w_busy_d;
            r_mask_q        <= w_mask_d;
            r_slots_q       <= w_slots_d;
            r_state_q       <= w_state_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha_mem_responder.sv
// ============================================================================
// Module      : tb_sha_mem_responder
// Description : Self-checking bench for sha_mem_responder with a read-data
//               scoreboard and an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sha_mem_responder;
    import sha_mem_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                eng_busy;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_write_data;
    logic [DATA_W-1:0]   mem_read_data;
    logic                host_req;
    logic                host_we;
    logic [ADDR_W-1:0]   host_addr;
    logic [DATA_W-1:0]   host_wdata;
    logic                host_grant;
    logic [DATA_W-1:0]   host_rdata;
    logic                host_rvalid;
    logic [ADDR_W-1:0]   digest_base;
    logic                digest_clear;
    logic [DIGEST_W-1:0] digest;
    logic                digest_valid;
    logic                addr_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;
    logic [31:0] hw [8];
    logic [255:0] exp_d;

    always #5 clk = ~clk;

    sha_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .eng_busy(eng_busy), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_grant(host_grant),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .digest_base(digest_base), .digest_clear(digest_clear),
        .digest(digest), .digest_valid(digest_valid), .addr_err(addr_err)
    );

    task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_write_data = d;
        if (a < 16'(DEPTH)) model_mem[a[9:0]] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; eng_busy = 1'b0; mem_we = 1'b0; mem_addr = '0;
        mem_write_data = '0; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
        host_wdata = '0; digest_base = 16'h0100; digest_clear = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_read_data, host_rdata, host_rvalid, digest_valid, addr_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_scalars: got %h/%h/%b/%b/%b expected all zero",
                     mem_read_data, host_rdata, host_rvalid, digest_valid, addr_err);
        end
        n_checks++;
        if (digest !== '0) begin
            n_errors++;
            $display("FAIL reset_digest: got %h expected 0", digest);
        end
        reset = 1'b0;
    endtask

    task automatic test_host_rw();
        int rd_list [3];
        rd_list = '{5, 0, 19};
        for (int a = 0; a < 20; a++) begin
            @(negedge clk);
            host_req = 1'b1; host_we = 1'b1; host_addr = 16'(a);
            host_wdata = 32'h61626364 + 32'(a);
            model_mem[a] = host_wdata;
            #1;
            n_checks++;
            if (host_grant !== 1'b1) begin
                n_errors++;
                $display("FAIL host_write_grant: addr %0d got %b expected 1", a, host_grant);
            end
        end
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_w = exp_q.pop_front();
                n_checks++;
                if (host_rvalid !== 1'b1 || host_rdata !== exp_w) begin
                    n_errors++;
                    $display("FAIL host_read: rvalid %b data %h expected rvalid 1 data %h",
                             host_rvalid, host_rdata, exp_w);
                end
            end
            if (i < 3) begin
                host_req = 1'b1; host_we = 1'b0; host_addr = 16'(rd_list[i]);
                exp_q.push_back(model_mem[rd_list[i]]);
                #1;
                n_checks++;
                if (host_grant !== 1'b1) begin
                    n_errors++;
                    $display("FAIL host_read_grant: got %b expected 1", host_grant);
                end
            end else begin
                host_req = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (host_rvalid !== 1'b0 || host_rdata !== model_mem[19]) begin
            n_errors++;
            $display("FAIL host_rdata_hold: rvalid %b data %h expected rvalid 0 data %h",
                     host_rvalid, host_rdata, model_mem[19]);
        end
    endtask

    task automatic test_engine_read();
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'd7;
        eng_busy = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_w = exp_q.pop_front();
                n_checks++;
                if (mem_read_data !== exp_w) begin
                    n_errors++;
                    $display("FAIL engine_read: addr %0d got %h expected %h",
                             i - 1, mem_read_data, exp_w);
                end
            end
            if (i < 20) begin
                mem_addr = 16'(i);
                exp_q.push_back(model_mem[i]);
            end
            #1;
            n_checks++;
            if (host_grant !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_grant: got %b expected 0", host_grant);
            end
        end
        host_req = 1'b0;
    endtask

    task automatic test_digest_capture();
        for (int k = 0; k < 8; k++) begin
            hw[k] = 32'hbdd2fbf9 + 32'(k) * 32'h11111111;
            exp_d[255 - 32*k -: 32] = hw[k];
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if (digest_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL capture_early_valid: after %0d writes got %b expected 0",
                             k, digest_valid);
                end
            end
            eng_write(16'h0100 + 16'(k), hw[k]);
        end
        @(negedge clk);
        mem_we = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b1 || digest !== exp_d) begin
            n_errors++;
            $display("FAIL capture_complete: valid %b digest %h expected valid 1 digest %h",
                     digest_valid, digest, exp_d);
        end
        eng_busy = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (digest_valid !== 1'b1 || digest !== exp_d) begin
            n_errors++;
            $display("FAIL digest_hold_idle: valid %b digest %h expected valid 1 digest %h",
                     digest_valid, digest, exp_d);
        end
    endtask

    task automatic test_rewrite();
        int seq [9];
        seq = '{3, 0, 1, 2, 3, 4, 5, 6, 7};
        @(negedge clk);
        eng_busy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (digest_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_rise_clear: got %b expected 0", digest_valid);
        end
        for (int i = 0; i <= 9; i++) begin
            if (i > 0) begin
                n_checks++;
                if (digest_valid !== logic'(i == 9)) begin
                    n_errors++;
                    $display("FAIL rewrite_valid: after %0d writes got %b expected %b",
                             i, digest_valid, logic'(i == 9));
                end
            end
            if (i < 9) begin
                eng_write(16'h0100 + 16'(seq[i]),
                          (i == 0) ? 32'h11111111 :
                          (i == 4) ? 32'h22222222 : 32'ha0000000 + 32'(seq[i]));
                @(negedge clk);
            end else begin
                mem_we = 1'b0;
            end
        end
        n_checks++;
        if (digest[159:128] !== 32'h22222222) begin
            n_errors++;
            $display("FAIL rewrite_slot3: got %h expected 22222222", digest[159:128]);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        digest_clear = 1'b1;
        eng_write(16'h0100, 32'hc0c0c0c0);
        @(negedge clk);
        digest_clear = 1'b0; mem_we = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_with_write: valid got %b expected 0", digest_valid);
        end
        for (int s = 1; s < 8; s++) begin
            eng_write(16'h0100 + 16'(s), 32'hb0000000 + 32'(s));
            @(negedge clk);
        end
        mem_we = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b1 || digest[255:224] !== 32'hc0c0c0c0) begin
            n_errors++;
            $display("FAIL clear_slot0_kept: valid %b h0 %h expected valid 1 h0 c0c0c0c0",
                     digest_valid, digest[255:224]);
        end
        eng_busy = 1'b0;
        @(negedge clk);
        eng_busy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (digest_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL new_hash_clear: valid got %b expected 0", digest_valid);
        end
        for (int s = 1; s < 8; s++) begin
            eng_write(16'h0100 + 16'(s), 32'hd0000000 + 32'(s));
            @(negedge clk);
        end
        mem_we = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mask_cleared: seven slots gave valid %b expected 0", digest_valid);
        end
        eng_write(16'h0100, 32'he0e0e0e0);
        @(negedge clk);
        mem_we = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b1 || digest[255:224] !== 32'he0e0e0e0) begin
            n_errors++;
            $display("FAIL refill_complete: valid %b h0 %h expected valid 1 h0 e0e0e0e0",
                     digest_valid, digest[255:224]);
        end
    endtask

    task automatic test_addr_err();
        eng_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (addr_err !== 1'b0) begin
            n_errors++;
            $display("FAIL addr_err_pre: got %b expected 0", addr_err);
        end
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'd1024; host_wdata = 32'hdeadbeef;
        @(negedge clk);
        host_we = 1'b0; host_addr = 16'd0;
        exp_q.push_back(model_mem[0]);
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_errors++;
            $display("FAIL addr_err_set: got %b expected 1", addr_err);
        end
        @(negedge clk);
        exp_w = exp_q.pop_front();
        n_checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== exp_w) begin
            n_errors++;
            $display("FAIL oor_write_dropped: data %h expected %h", host_rdata, exp_w);
        end
        host_addr = 16'd1024;
        exp_q.push_back(32'h0);
        @(negedge clk);
        host_req = 1'b0;
        exp_w = exp_q.pop_front();
        n_checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== exp_w) begin
            n_errors++;
            $display("FAIL host_oor_read: data %h expected %h", host_rdata, exp_w);
        end
        eng_busy = 1'b1; mem_addr = 16'd1;
        exp_q.push_back(model_mem[1]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) begin
                mem_addr = 16'hffff;
                exp_q.push_back(32'h0);
            end
            exp_w = exp_q.pop_front();
            n_checks++;
            if (mem_read_data !== exp_w) begin
                n_errors++;
                $display("FAIL engine_oor_seq: step %0d got %h expected %h",
                         i, mem_read_data, exp_w);
            end
        end
        mem_addr = 16'd2;
        repeat (3) @(negedge clk);
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_errors++;
            $display("FAIL addr_err_sticky: got %b expected 1", addr_err);
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 4; s++) begin
            eng_write(16'h0100 + 16'(s), 32'h5a000000 + 32'(s));
            @(negedge clk);
        end
        mem_we = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0 || addr_err !== 1'b0 || digest !== '0 ||
            mem_read_data !== '0 || host_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_capture: valid %b err %b rd %h expected all zero",
                     digest_valid, addr_err, mem_read_data);
        end
        eng_busy = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'd5;
        exp_q.push_back(model_mem[5]);
        @(negedge clk);
        host_req = 1'b0;
        exp_w = exp_q.pop_front();
        n_checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== exp_w) begin
            n_errors++;
            $display("FAIL array_survives_reset: data %h expected %h", host_rdata, exp_w);
        end
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_engine_read();
        test_digest_capture();
        test_rewrite();
        test_clear();
        test_addr_err();
        test_reset_mid();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
